// File: rtl/unidade_controle_rodadas_pkg.sv
// State codes and state type for the round controller of the memory game.
// The 4-bit codes are the same ones that the seven-segment debug display shows.
package unidade_controle_rodadas_pkg;

  localparam logic [3:0] COD_INICIAL       = 4'h0;
  localparam logic [3:0] COD_PREPARA       = 4'h1;
  localparam logic [3:0] COD_INICIO_RODADA = 4'h2;
  localparam logic [3:0] COD_LEDS_ON       = 4'h3;
  localparam logic [3:0] COD_LEDS_OFF      = 4'h4;
  localparam logic [3:0] COD_PROX_LED      = 4'h5;
  localparam logic [3:0] COD_PREP_JOGADA   = 4'h6;
  localparam logic [3:0] COD_ESPERA        = 4'h7;
  localparam logic [3:0] COD_REGISTRA      = 4'h8;
  localparam logic [3:0] COD_COMPARA       = 4'h9;
  localparam logic [3:0] COD_PROX_JOGADA   = 4'hA;
  localparam logic [3:0] COD_PROX_RODADA   = 4'hB;
  localparam logic [3:0] COD_FIM_ACERTO    = 4'hC;
  localparam logic [3:0] COD_FIM_TIMEOUT   = 4'hD;
  localparam logic [3:0] COD_FIM_ERRO      = 4'hE;

  typedef enum logic [3:0] {
    INICIAL       = COD_INICIAL,
    PREPARA       = COD_PREPARA,
    INICIO_RODADA = COD_INICIO_RODADA,
    LEDS_ON       = COD_LEDS_ON,
    LEDS_OFF      = COD_LEDS_OFF,
    PROX_LED      = COD_PROX_LED,
    PREP_JOGADA   = COD_PREP_JOGADA,
    ESPERA        = COD_ESPERA,
    REGISTRA      = COD_REGISTRA,
    COMPARA       = COD_COMPARA,
    PROX_JOGADA   = COD_PROX_JOGADA,
    PROX_RODADA   = COD_PROX_RODADA,
    FIM_ACERTO    = COD_FIM_ACERTO,
    FIM_TIMEOUT   = COD_FIM_TIMEOUT,
    FIM_ERRO      = COD_FIM_ERRO
  } estado_t;

endpackage

// File: rtl/unidade_controle_rodadas.sv
// Moore round controller for the memory game: replays the sequence on the LEDs,
// then collects and checks the player's moves, growing the sequence each round.
module unidade_controle_rodadas
  import unidade_controle_rodadas_pkg::*;
#(
  parameter bit REPLAY_ALL = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fimS,
  input  logic       fimLedsOn,
  input  logic       fimLedsOff,
  input  logic       timeout,
  input  logic       enderecoIgualSequencia,
  input  logic       tem_jogada,
  input  logic       jogadaIgualMemoria,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraS,
  output logic       contaS,
  output logic       zeraR,
  output logic       registraR,
  output logic       estado_espera,
  output logic       estado_ledsOn,
  output logic       estado_ledsOff,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t estado, proximo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  // Outputs depend on the state only; the unused code 0xF falls back to INICIAL.
  always_comb begin
    proximo        = INICIAL;
    zeraE          = 1'b0;
    contaE         = 1'b0;
    zeraS          = 1'b0;
    contaS         = 1'b0;
    zeraR          = 1'b0;
    registraR      = 1'b0;
    estado_espera  = 1'b0;
    estado_ledsOn  = 1'b0;
    estado_ledsOff = 1'b0;
    acertou        = 1'b0;
    errou          = 1'b0;
    pronto         = 1'b0;
    db_estado      = estado;
    case (estado)
      INICIAL: proximo = iniciar ? PREPARA : INICIAL;
      PREPARA: begin
        zeraE   = 1'b1;
        zeraS   = 1'b1;
        zeraR   = 1'b1;
        proximo = INICIO_RODADA;
      end
      // Show-only-new mode keeps E where the last round left it (S-1, or 0 after
      // PREPARA), so stepping through PROX_LED until E==S lands on position S.
      INICIO_RODADA: begin
        zeraE = REPLAY_ALL;
        zeraR = 1'b1;
        if (REPLAY_ALL || enderecoIgualSequencia) proximo = LEDS_ON;
        else                                      proximo = PROX_LED;
      end
      LEDS_ON: begin
        estado_ledsOn = 1'b1;
        proximo       = fimLedsOn ? LEDS_OFF : LEDS_ON;
      end
      LEDS_OFF: begin
        estado_ledsOff = 1'b1;
        if (!fimLedsOff)                 proximo = LEDS_OFF;
        else if (enderecoIgualSequencia) proximo = PREP_JOGADA;
        else                             proximo = PROX_LED;
      end
      PROX_LED: begin
        contaE  = 1'b1;
        proximo = LEDS_ON;
      end
      PREP_JOGADA: begin
        zeraE   = 1'b1;
        zeraR   = 1'b1;
        proximo = ESPERA;
      end
      ESPERA: begin
        estado_espera = 1'b1;
        if (tem_jogada)   proximo = REGISTRA;
        else if (timeout) proximo = FIM_TIMEOUT;
        else              proximo = ESPERA;
      end
      REGISTRA: begin
        registraR = 1'b1;
        proximo   = COMPARA;
      end
      COMPARA: begin
        if (!jogadaIgualMemoria)          proximo = FIM_ERRO;
        else if (!enderecoIgualSequencia) proximo = PROX_JOGADA;
        else if (fimS)                    proximo = FIM_ACERTO;
        else                              proximo = PROX_RODADA;
      end
      PROX_JOGADA: begin
        contaE  = 1'b1;
        proximo = ESPERA;
      end
      PROX_RODADA: begin
        contaS  = 1'b1;
        proximo = INICIO_RODADA;
      end
      FIM_ACERTO: begin
        acertou = 1'b1;
        pronto  = 1'b1;
        proximo = iniciar ? PREPARA : FIM_ACERTO;
      end
      FIM_TIMEOUT: begin
        errou   = 1'b1;
        pronto  = 1'b1;
        proximo = iniciar ? PREPARA : FIM_TIMEOUT;
      end
      FIM_ERRO: begin
        errou   = 1'b1;
        pronto  = 1'b1;
        proximo = iniciar ? PREPARA : FIM_ERRO;
      end
      default: proximo = INICIAL;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for the round controller: two instances (full replay and show-only-new)
// driven against a small behavioural model of the counters, move register and memory.
module tb_unidade_controle_rodadas;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [1:0] iniciar, tem_jogada, timeout, fim_s, igual_es, jogada_ok;
  logic [1:0] zera_e, conta_e, zera_s, conta_s, zera_r, registra_r;
  logic [1:0] espera, leds_on, leds_off, acertou, errou, pronto;
  logic [3:0] db[2];
  logic [1:0] fim_leds = 2'b11;

  unidade_controle_rodadas #(.REPLAY_ALL(1'b1)) u0 (
    .clock(clock), .reset(reset), .iniciar(iniciar[0]), .fimS(fim_s[0]),
    .fimLedsOn(fim_leds[0]), .fimLedsOff(fim_leds[0]), .timeout(timeout[0]),
    .enderecoIgualSequencia(igual_es[0]), .tem_jogada(tem_jogada[0]),
    .jogadaIgualMemoria(jogada_ok[0]), .zeraE(zera_e[0]), .contaE(conta_e[0]),
    .zeraS(zera_s[0]), .contaS(conta_s[0]), .zeraR(zera_r[0]), .registraR(registra_r[0]),
    .estado_espera(espera[0]), .estado_ledsOn(leds_on[0]), .estado_ledsOff(leds_off[0]),
    .acertou(acertou[0]), .errou(errou[0]), .pronto(pronto[0]), .db_estado(db[0])
  );

  unidade_controle_rodadas #(.REPLAY_ALL(1'b0)) u1 (
    .clock(clock), .reset(reset), .iniciar(iniciar[1]), .fimS(fim_s[1]),
    .fimLedsOn(fim_leds[1]), .fimLedsOff(fim_leds[1]), .timeout(timeout[1]),
    .enderecoIgualSequencia(igual_es[1]), .tem_jogada(tem_jogada[1]),
    .jogadaIgualMemoria(jogada_ok[1]), .zeraE(zera_e[1]), .contaE(conta_e[1]),
    .zeraS(zera_s[1]), .contaS(conta_s[1]), .zeraR(zera_r[1]), .registraR(registra_r[1]),
    .estado_espera(espera[1]), .estado_ledsOn(leds_on[1]), .estado_ledsOff(leds_off[1]),
    .acertou(acertou[1]), .errou(errou[1]), .pronto(pronto[1]), .db_estado(db[1])
  );

  // Datapath model: N=4 memory, address/sequence counters, move register.
  logic [1:0] mem[4];
  logic [1:0] e_cnt[2], s_cnt[2], jreg[2], jog[2], e_on[2];
  logic [1:0] leds_on_q;
  int conta_s_n[2], flashes[2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        e_cnt[i] <= '0; s_cnt[i] <= '0; jreg[i] <= '0; e_on[i] <= '0;
        conta_s_n[i] <= 0; flashes[i] <= 0;
      end
      leds_on_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (zera_e[i]) e_cnt[i] <= '0;
        else if (conta_e[i]) e_cnt[i] <= e_cnt[i] + 2'd1;
        if (zera_s[i]) s_cnt[i] <= '0;
        else if (conta_s[i]) s_cnt[i] <= s_cnt[i] + 2'd1;
        if (zera_r[i]) jreg[i] <= '0;
        else if (registra_r[i]) jreg[i] <= jog[i];
        if (leds_on[i]) e_on[i] <= e_cnt[i];
        if (conta_s[i]) conta_s_n[i] <= conta_s_n[i] + 1;
        if (leds_on[i] && !leds_on_q[i]) flashes[i] <= flashes[i] + 1;
      end
      leds_on_q <= leds_on;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fim_s[i]     = (s_cnt[i] == 2'd3);
      igual_es[i]  = (e_cnt[i] == s_cnt[i]);
      jogada_ok[i] = (jreg[i] == mem[e_cnt[i]]);
    end
  end

  // Scoreboard: expected state after each clock, and expected {acertou,errou,pronto}.
  logic [3:0] exp_q[$];
  logic [2:0] verd_q[$];
  logic [3:0] exp_v;
  logic [2:0] verd_v;
  logic       prev_pronto = 1'b0;
  int sel = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clock) begin
    #2;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (db[sel] !== exp_v) begin
        errors++;
        $display("FAIL state_trace u%0d: got %h expected %h", sel, db[sel], exp_v);
      end
    end
    if (pronto[sel] && !prev_pronto) begin
      checks++;
      if (verd_q.size() == 0) begin
        errors++;
        $display("FAIL verdict u%0d: unexpected pronto, state %h", sel, db[sel]);
      end else begin
        verd_v = verd_q.pop_front();
        if ({acertou[sel], errou[sel], pronto[sel]} !== verd_v) begin
          errors++;
          $display("FAIL verdict u%0d: got %b expected %b", sel,
                   {acertou[sel], errou[sel], pronto[sel]}, verd_v);
        end
      end
    end
    prev_pronto = pronto[sel];
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Inputs set here act on the next rising edge; exp is the state after it.
  task automatic step(input logic ini, input logic tem, input logic tmo,
                      input logic [1:0] j, input logic [3:0] exp);
    @(negedge clock);
    iniciar[sel]    = ini;
    tem_jogada[sel] = tem;
    timeout[sel]    = tmo;
    jog[sel]        = j;
    exp_q.push_back(exp);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(posedge clock);
      #3;
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected states left", exp_q.size());
      exp_q.delete();
    end
  endtask

  // One round at sequence index s; bad >= 0 plays a wrong move at that position.
  task automatic play_round(input int s, input int bad);
    logic [1:0] v;
    step(0, 0, 0, 0, 4'h2);
    if (sel == 0) begin
      for (int e = 0; e <= s; e++) begin
        step(0, 0, 0, 0, 4'h3);
        step(0, 0, 0, 0, 4'h4);
        if (e < s) step(0, 0, 0, 0, 4'h5);
      end
    end else begin
      if (s > 0) step(0, 0, 0, 0, 4'h5);
      step(0, 0, 0, 0, 4'h3);
      step(0, 0, 0, 0, 4'h4);
    end
    step(0, 0, 0, 0, 4'h6);
    step(0, 0, 0, 0, 4'h7);
    for (int e = 0; e <= s; e++) begin
      v = (e == bad) ? (mem[e] ^ 2'b01) : mem[e];
      step(0, 1, 0, v, 4'h8);
      step(0, 0, 0, v, 4'h9);
      if (e == bad) begin
        step(0, 0, 0, v, 4'hE);
        return;
      end
      if (e < s) begin
        step(0, 0, 0, v, 4'hA);
        step(0, 0, 0, v, 4'h7);
      end else begin
        step(0, 0, 0, v, (s == 3) ? 4'hC : 4'hB);
      end
    end
  endtask

  int f0;

  initial begin
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;
    iniciar = '0; tem_jogada = '0; timeout = '0;
    jog[0] = '0; jog[1] = '0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_state", int'(db[0]), 0);
    chk("reset_outputs", int'({zera_e[0], conta_e[0], zera_s[0], conta_s[0], zera_r[0],
        registra_r[0], espera[0], leds_on[0], leds_off[0], acertou[0], errou[0], pronto[0]}), 0);
    reset = 1'b1;
    step(0, 0, 0, 0, 4'h0);
    step(0, 0, 0, 0, 4'h0);

    // Full N=4 game, every move correct.
    verd_q.push_back(3'b101);
    step(1, 0, 0, 0, 4'h1);
    for (int s = 0; s < 4; s++) play_round(s, -1);
    drain();
    chk("conta_s_pulses", conta_s_n[0], 3);
    chk("led_flashes", flashes[0], 1 + 2 + 3 + 4);

    // Restart with iniciar held in FIM_ACERTO, wrong move at round 2 position 1.
    verd_q.push_back(3'b011);
    step(1, 0, 0, 0, 4'h1);
    play_round(0, -1);
    play_round(1, -1);
    play_round(2, 1);
    drain();
    chk("erro_acertou_low", int'(acertou[0]), 0);

    // Timeout, then restart; a move coinciding with timeout wins.
    verd_q.push_back(3'b011);
    step(1, 0, 0, 0, 4'h1);
    step(0, 0, 0, 0, 4'h2);
    step(0, 0, 0, 0, 4'h3);
    step(0, 0, 0, 0, 4'h4);
    step(0, 0, 0, 0, 4'h6);
    step(0, 0, 0, 0, 4'h7);
    step(0, 0, 0, 0, 4'h7);
    step(0, 0, 0, 0, 4'h7);
    step(0, 0, 1, 0, 4'hD);
    step(1, 0, 0, 0, 4'h1);
    step(0, 0, 0, 0, 4'h2);
    step(0, 0, 0, 0, 4'h3);
    step(0, 0, 0, 0, 4'h4);
    step(0, 0, 0, 0, 4'h6);
    step(0, 0, 0, 0, 4'h7);
    step(0, 1, 1, mem[0], 4'h8);
    step(0, 0, 0, mem[0], 4'h9);
    step(0, 0, 0, mem[0], 4'hB);
    step(0, 0, 0, 0, 4'h2);
    step(0, 0, 0, 0, 4'h3);
    drain();

    // Asynchronous reset while in LEDS_ON.
    chk("pre_reset_leds_on", int'(db[0]), 3);
    reset = 1'b0;
    #1;
    chk("async_reset_state", int'(db[0]), 0);
    chk("async_reset_outputs", int'({zera_e[0], conta_e[0], zera_s[0], conta_s[0], zera_r[0],
        registra_r[0], espera[0], leds_on[0], leds_off[0], acertou[0], errou[0], pronto[0]}), 0);
    @(negedge clock);
    reset = 1'b1;
    step(0, 0, 0, 0, 4'h0);
    step(0, 0, 0, 0, 4'h0);
    step(0, 0, 0, 0, 4'h0);
    drain();

    // Show-only-new instance: full game, one flash per round at position S.
    sel = 1;
    prev_pronto = 1'b0;
    verd_q.push_back(3'b101);
    step(1, 0, 0, 0, 4'h1);
    for (int s = 0; s < 3; s++) play_round(s, -1);
    drain();
    f0 = flashes[1];
    play_round(3, -1);
    drain();
    chk("single_new_flash", flashes[1] - f0, 1);
    chk("e_during_flash", int'(e_on[1]), 3);
    chk("total_new_flashes", flashes[1], 4);
    step(1, 0, 0, 0, 4'h1);
    step(0, 0, 0, 0, 4'h2);
    drain();
    chk("verdicts_consumed", verd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
